relogio_param_core: RTL and testbench
=====================================

RELOGIO_PARAM_CORE -- requirements
Module: relogio_param_core

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning input clock cycles per one-second tick.
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each display digit stays active.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_mode, input, 1 bit: asynchronous, already debounced; cycles the set mode.
REQ-007 The block SHALL have port btn_inc, input, 1 bit: asynchronous, already debounced; increments the field being set.
REQ-008 The block SHALL have port mode12, input, 1 bit: 1 = 12-hour display, 0 = 24-hour display.
REQ-009 The block SHALL have port show_sec, input, 1 bit: 0 = display HH:MM, 1 = display MM:SS.
REQ-010 The block SHALL have port seg, output, 7 bits: active-low segments gfedcba of the active digit.
REQ-011 The block SHALL have port an, output, 4 bits: active-low one-hot digit enable; an[0] is the rightmost digit.
REQ-012 The block SHALL have port pm, output, 1 bit: 1 when the hour is 12..23, in both display modes.
REQ-013 The block SHALL have port led, output, 1 bit: toggles on every tick.

Function
REQ-014 The block SHALL run a prescaler from 0 to CLK_FREQ-1 that wraps and asserts an internal tick for one cycle at CLK_FREQ-1, sized to the minimum width for CLK_FREQ-1.
REQ-015 The block SHALL hold time as six BCD digits (s_lo, s_hi, m_lo, m_hi, h_lo, h_hi), always in 24-hour form 00:00:00..23:59:59.
REQ-016 In RUN, on each tick edge seconds SHALL increment; all carries (59 s to 00 with minute+1, 59:59 to hour+1, 23:59:59 to 00:00:00) SHALL resolve on the same edge.
REQ-017 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector; a one-cycle edge pulse SHALL appear 3 clk edges after the input rises.
REQ-018 The FSM SHALL have states RUN, SET_H and SET_M, with transitions on btn_mode edges: RUN to SET_H, SET_H to SET_M, SET_M to RUN.
REQ-019 In SET_H, a btn_inc edge SHALL increment the hour, wrapping 23 to 00 with no other digit affected.
REQ-020 In SET_M, a btn_inc edge SHALL increment the minute, wrapping 59 to 00 with no hour carry.
REQ-021 In RUN, btn_inc SHALL be ignored.
REQ-022 In SET_H and SET_M, time SHALL NOT advance on ticks, but the prescaler and led SHALL keep running.
REQ-023 On the SET_M to RUN transition, seconds SHALL clear to 00 and the prescaler SHALL clear to 0 on the same edge.
REQ-024 If btn_mode and btn_inc edges occur in the same cycle, the mode transition SHALL win and the increment SHALL be discarded.
REQ-025 When led=1, the field being set SHALL be blanked (seg=7'b1111111): both hour digits in SET_H, both minute digits in SET_M, and only when those digits are displayed.
REQ-026 The 12-hour display map SHALL be: hour 0 shows 12, 1..12 show as-is, 13..23 show hour-12; a hour-tens digit of 0 SHALL be blanked in 12-hour mode only.
REQ-027 The scan counter SHALL run from 0 to SCAN_DIV-1; at its wrap the digit index SHALL advance 0,1,2,3,0 and an SHALL cycle 1110, 1101, 1011, 0111.
REQ-028 Digit mapping SHALL be: index 0 = minute-ones (show_sec=0) or second-ones (show_sec=1); index 3 = hour-tens or minute-tens.
REQ-029 seg SHALL be combinational from the registered digit index and time; patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other value SHALL produce 1111111.
REQ-030 A change to mode12 or show_sec SHALL take effect at the next displayed digit, with no state change.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force: time 00:00:00, state RUN, prescaler 0, scan counter 0, digit index 0, synchronizers and edge detectors 0, led=0.
REQ-032 During reset the outputs SHALL be an=1110, seg=1000000, pm=0; reset asserted mid-SET SHALL abandon the edit.
REQ-033 After rst rises, the first tick SHALL occur CLK_FREQ edges later.

Verification (CLK_FREQ=10, SCAN_DIV=4)
REQ-034 Scenario: release reset, run 600 ticks -> time 00:10:00, led=0, state RUN.
REQ-035 Scenario: set hour 23 and minute 59, exit to RUN, run 60 ticks -> 00:00:00 on the 60th tick edge, pm goes 1 to 0.
REQ-036 Scenario: mode12=1 with hour 13 -> hour digits show blank and 1, pm=1; with hour 00 -> 12, pm=0.
REQ-037 Scenario: btn_mode, then 25 btn_inc -> hour 01; btn_mode, then 60 btn_inc -> minute 00 with hour still 01; simultaneous btn_mode and btn_inc -> only the state changes.
REQ-038 Scenario: assert rst mid-SET_M -> immediately RUN, 00:00:00, an=1110, seg=1000000.
REQ-039 Scenario: show_sec=1 at 12:34:56 -> an cycles 1110, 1101, 1011, 0111 every 4 cycles with digits 6, 5, 4, 3.

Source files
------------

// File: rtl/relogio_param_core.sv
// Digital clock core: BCD time keeping with hour/minute setting, 12/24-hour
// view and a multiplexed active-low 4-digit seven-segment display.
module relogio_param_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       mode12,
  input  logic       show_sec,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       pm,
  output logic       led
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SET_H = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;

  localparam logic [3:0] BLANK = 4'hF;

  logic [PW-1:0] presc_q, presc_d;
  logic          led_q;
  logic [2:0]    mode_sync_q, inc_sync_q;
  logic          mode_edge_q, inc_edge_q;
  logic [1:0]    state_q, state_d;
  logic [3:0]    s_lo_q, s_hi_q, m_lo_q, m_hi_q, h_lo_q, h_hi_q;
  logic [3:0]    s_lo_d, s_hi_d, m_lo_d, m_hi_d, h_lo_d, h_hi_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;

  logic          tick;
  logic          run_tick;
  logic          leave_set;
  logic          min_step;
  logic          hour_step;
  logic [4:0]    hour_bin;
  logic [4:0]    hour_12;
  logic [3:0]    hr_tens, hr_ones;
  logic [3:0]    digit;
  logic          field_blank;

  assign tick      = (presc_q == PRESC_MAX);
  assign run_tick  = tick && (state_q == ST_RUN);
  assign leave_set = mode_edge_q && (state_q == ST_SET_M);

  // Leaving SET_M restarts the second so the first tick is a full period away.
  assign presc_d = (tick || leave_set) ? '0 : presc_q + 1'b1;

  assign scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + 1'b1;
  assign idx_d  = (scan_q == SCAN_MAX) ? idx_q + 2'd1 : idx_q;

  always_comb begin
    state_d   = state_q;
    s_lo_d    = s_lo_q;
    s_hi_d    = s_hi_q;
    m_lo_d    = m_lo_q;
    m_hi_d    = m_hi_q;
    h_lo_d    = h_lo_q;
    h_hi_d    = h_hi_q;
    min_step  = 1'b0;
    hour_step = 1'b0;

    if (run_tick) begin
      if (s_lo_q == 4'd9) begin
        s_lo_d = 4'd0;
        if (s_hi_q == 4'd5) begin
          s_hi_d   = 4'd0;
          min_step = 1'b1;
        end else begin
          s_hi_d = s_hi_q + 4'd1;
        end
      end else begin
        s_lo_d = s_lo_q + 4'd1;
      end
    end

    // A mode edge takes priority; a coincident increment is dropped.
    if (mode_edge_q) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        default: begin
          state_d = ST_RUN;
          s_lo_d  = 4'd0;
          s_hi_d  = 4'd0;
        end
      endcase
    end else if (inc_edge_q) begin
      if (state_q == ST_SET_H) begin
        hour_step = 1'b1;
      end else if (state_q == ST_SET_M) begin
        min_step = 1'b1;
      end
    end

    if (min_step) begin
      if (m_lo_q == 4'd9) begin
        m_lo_d = 4'd0;
        if (m_hi_q == 4'd5) begin
          m_hi_d    = 4'd0;
          hour_step = run_tick;  // only a running clock carries into the hour
        end else begin
          m_hi_d = m_hi_q + 4'd1;
        end
      end else begin
        m_lo_d = m_lo_q + 4'd1;
      end
    end

    if (hour_step) begin
      if (h_hi_q == 4'd2 && h_lo_q == 4'd3) begin
        h_hi_d = 4'd0;
        h_lo_d = 4'd0;
      end else if (h_lo_q == 4'd9) begin
        h_lo_d = 4'd0;
        h_hi_d = h_hi_q + 4'd1;
      end else begin
        h_lo_d = h_lo_q + 4'd1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      led_q       <= 1'b0;
      mode_sync_q <= 3'b000;
      inc_sync_q  <= 3'b000;
      mode_edge_q <= 1'b0;
      inc_edge_q  <= 1'b0;
      state_q     <= ST_RUN;
      s_lo_q      <= 4'd0;
      s_hi_q      <= 4'd0;
      m_lo_q      <= 4'd0;
      m_hi_q      <= 4'd0;
      h_lo_q      <= 4'd0;
      h_hi_q      <= 4'd0;
      scan_q      <= '0;
      idx_q       <= 2'd0;
    end else begin
      presc_q     <= presc_d;
      led_q       <= led_q ^ tick;
      mode_sync_q <= {mode_sync_q[1:0], btn_mode};
      inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
      mode_edge_q <= mode_sync_q[1] & ~mode_sync_q[2];
      inc_edge_q  <= inc_sync_q[1] & ~inc_sync_q[2];
      state_q     <= state_d;
      s_lo_q      <= s_lo_d;
      s_hi_q      <= s_hi_d;
      m_lo_q      <= m_lo_d;
      m_hi_q      <= m_hi_d;
      h_lo_q      <= h_lo_d;
      h_hi_q      <= h_hi_d;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    hour_bin = (5'(h_hi_q) * 5'd10) + 5'(h_lo_q);
    hour_12  = hour_bin;
    if (hour_bin == 5'd0) begin
      hour_12 = 5'd12;
    end else if (hour_bin > 5'd12) begin
      hour_12 = hour_bin - 5'd12;
    end

    if (mode12) begin
      if (hour_12 >= 5'd10) begin
        hr_tens = 4'd1;
        hr_ones = 4'(hour_12 - 5'd10);
      end else begin
        hr_tens = BLANK;
        hr_ones = hour_12[3:0];
      end
    end else begin
      hr_tens = h_hi_q;
      hr_ones = h_lo_q;
    end
  end

  // The field under edit flashes with the one-second led.
  always_comb begin
    digit       = BLANK;
    field_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        digit       = show_sec ? s_lo_q : m_lo_q;
        field_blank = !show_sec && (state_q == ST_SET_M);
      end
      2'd1: begin
        digit       = show_sec ? s_hi_q : m_hi_q;
        field_blank = !show_sec && (state_q == ST_SET_M);
      end
      2'd2: begin
        digit       = show_sec ? m_lo_q : hr_ones;
        field_blank = show_sec ? (state_q == ST_SET_M) : (state_q == ST_SET_H);
      end
      default: begin
        digit       = show_sec ? m_hi_q : hr_tens;
        field_blank = show_sec ? (state_q == ST_SET_M) : (state_q == ST_SET_H);
      end
    endcase
    if (led_q && field_blank) begin
      digit = BLANK;
    end
  end

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign an  = ~(4'b0001 << idx_q);
  assign pm  = (hour_bin >= 5'd12);
  assign led = led_q;

endmodule

// File: tb/tb_relogio_param_core.sv
// Self-checking bench for relogio_param_core: a seconds-count reference model
// checked every cycle, plus literal display readouts for key scenarios.
module tb_relogio_param_core;

  localparam int CLK_FREQ = 10;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       mode12;
  logic       show_sec;
  logic [6:0] seg;
  logic [3:0] an;
  logic       pm;
  logic       led;

  relogio_param_core #(
    .CLK_FREQ(CLK_FREQ),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .mode12  (mode12),
    .show_sec(show_sec),
    .seg     (seg),
    .an      (an),
    .pm      (pm),
    .led     (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, mode 0=RUN 1=SET_H 2=SET_M.
  int         m_secs, m_mode, m_phase, m_n;
  bit         m_led, m_tick, ev_m, ev_i;
  logic [4:0] hist_m, hist_i;
  int         mh, mm, ms;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_secs = 0; m_mode = 0; m_phase = 0; m_n = 0; m_led = 0;
      hist_m = '0; hist_i = '0;
    end else begin
      m_n++;
      hist_m = {hist_m[3:0], btn_mode};
      hist_i = {hist_i[3:0], btn_inc};
      // a button acts on the 3rd edge after the edge that first sees it high
      ev_m = hist_m[3] && !hist_m[4];
      ev_i = hist_i[3] && !hist_i[4];
      m_tick  = (m_phase == CLK_FREQ - 1);
      m_phase = m_tick ? 0 : m_phase + 1;
      if (m_tick) m_led = !m_led;
      if (m_mode == 0 && m_tick) m_secs = (m_secs + 1) % 86400;
      if (ev_m) begin
        if (m_mode == 2) begin
          m_secs  = m_secs - (m_secs % 60);
          m_phase = 0;
        end
        m_mode = (m_mode + 1) % 3;
      end else if (ev_i) begin
        mh = m_secs / 3600; mm = (m_secs / 60) % 60; ms = m_secs % 60;
        if (m_mode == 1) mh = (mh + 1) % 24;
        else if (m_mode == 2) mm = (mm + 1) % 60;
        m_secs = mh * 3600 + mm * 60 + ms;
      end
    end
  end

  function automatic logic [6:0] exp_seg(input int idx);
    int h  = m_secs / 3600;
    int mn = (m_secs / 60) % 60;
    int s  = m_secs % 60;
    int dh, v;
    bit blk;
    if (show_sec) begin
      case (idx)
        0: v = s % 10;
        1: v = s / 10;
        2: v = mn % 10;
        default: v = mn / 10;
      endcase
    end else if (idx < 2) begin
      v = (idx == 0) ? mn % 10 : mn / 10;
    end else if (mode12) begin
      dh = (h % 12 == 0) ? 12 : h % 12;
      v  = (idx == 2) ? dh % 10 : ((dh / 10 == 0) ? 15 : dh / 10);
    end else begin
      v = (idx == 2) ? h % 10 : h / 10;
    end
    blk = m_led && ((m_mode == 1 && !show_sec && idx >= 2) ||
                    (m_mode == 2 && (show_sec ? idx >= 2 : idx < 2)));
    if (blk) v = 15;
    return (v < 10) ? seg_tab[v] : 7'b1111111;
  endfunction

  int         c_idx;
  logic [3:0] c_an;

  always @(negedge clk) begin
    if (rst) begin
      c_idx = (m_n / SCAN_DIV) % 4;
      c_an  = 4'hF ^ (4'b0001 << c_idx);
      check("cyc_an",  32'(an),  32'(c_an));
      check("cyc_seg", 32'(seg), 32'(exp_seg(c_idx)));
      check("cyc_pm",  32'(pm),  32'(m_secs >= 12 * 3600));
      check("cyc_led", 32'(led), 32'(m_led));
    end
  end

  function automatic int seg2dig(input logic [6:0] s);
    if (s == 7'b1111111) return 15;
    for (int k = 0; k < 10; k++) if (s == seg_tab[k]) return k;
    return -1;
  endfunction

  int rd [4];

  // Captures one full scan: rd[0] is the rightmost digit, 15 means blank.
  task automatic read_digits();
    int guard = 0;
    logic [3:0] e_an;
    @(negedge clk);
    while (an !== 4'b1110 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("scan_start_an", 32'(an), 32'(4'b1110));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (SCAN_DIV) @(negedge clk);
      e_an = 4'hF ^ (4'b0001 << k);
      check("scan_an", 32'(an), 32'(e_an));
      rd[k] = seg2dig(seg);
    end
  endtask

  task automatic press(input logic bm, input logic bi);
    @(posedge clk); #1;
    btn_mode = bm;
    btn_inc  = bi;
    repeat (2) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  task automatic do_reset_checked();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_an",  32'(an),  32'(4'b1110));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_pm",  32'(pm),  32'(0));
    check("rst_led", 32'(led), 32'(0));
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; mode12 = 1'b0; show_sec = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("init_an",  32'(an),  32'(4'b1110));
    check("init_seg", 32'(seg), 32'(7'b1000000));
    check("init_pm",  32'(pm),  32'(0));
    check("init_led", 32'(led), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // First tick lands exactly CLK_FREQ edges after reset release.
    repeat (CLK_FREQ - 1) @(posedge clk);
    #1 check("led_before_first_tick", 32'(led), 32'(0));
    @(posedge clk);
    #1 check("led_first_tick", 32'(led), 32'(1));

    // 600 ticks -> 00:10:00, led back to 0.
    repeat (600 * CLK_FREQ - CLK_FREQ) @(posedge clk);
    #1 check("led_600_ticks", 32'(led), 32'(0));
    read_digits();
    check("t600_m_lo", rd[0], 0);
    check("t600_m_hi", rd[1], 1);
    check("t600_h_lo", rd[2], 0);
    check("t600_h_hi", rd[3], 0);
    press_inc(2);  // ignored in RUN
    read_digits();
    check("run_inc_ignored_m_lo", rd[0], 0);

    // Set 23:59, return to RUN, 60 ticks roll over to 00:00:00.
    press(1'b1, 1'b0);
    press_inc(23);
    press(1'b1, 1'b0);
    press_inc(49);
    read_digits();
    check("set_h_lo_23", rd[2], 3);
    check("set_h_hi_23", rd[3], 2);
    press(1'b1, 1'b0);
    repeat (60 * CLK_FREQ - 3) @(posedge clk);
    #1 check("pm_before_rollover", 32'(pm), 32'(1));
    @(posedge clk);
    #1 check("pm_after_rollover", 32'(pm), 32'(0));
    read_digits();
    check("roll_m_lo", rd[0], 0);
    check("roll_m_hi", rd[1], 0);
    check("roll_h_lo", rd[2], 0);
    check("roll_h_hi", rd[3], 0);

    // 12-hour view: 00 -> "12", 13 -> " 1".
    mode12 = 1'b1;
    read_digits();
    check("h12_00_lo", rd[2], 2);
    check("h12_00_hi", rd[3], 1);
    check("h12_00_pm", 32'(pm), 32'(0));
    press(1'b1, 1'b0);
    press_inc(13);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    read_digits();
    check("h12_13_lo", rd[2], 1);
    check("h12_13_hi_blank", rd[3], 15);
    check("h12_13_pm", 32'(pm), 32'(1));
    mode12 = 1'b0;
    read_digits();
    check("h24_13_lo", rd[2], 3);
    check("h24_13_hi", rd[3], 1);

    // Hour wrap via 25 incs, minute wrap via 60 incs, simultaneous buttons.
    do_reset_checked();
    press(1'b1, 1'b0);
    press_inc(25);
    press(1'b1, 1'b0);
    press_inc(60);
    read_digits();
    check("hwrap_h_lo", rd[2], 1);
    check("hwrap_h_hi", rd[3], 0);
    press(1'b1, 1'b1);
    read_digits();
    check("simul_m_lo", rd[0], 0);
    check("simul_m_hi", rd[1], 0);
    check("simul_h_lo", rd[2], 1);
    check("simul_h_hi", rd[3], 0);

    // Reset in the middle of SET_M abandons the edit.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press_inc(3);
    do_reset_checked();
    press_inc(1);
    read_digits();
    check("post_rst_m_lo", rd[0], 0);
    check("post_rst_h_lo", rd[2], 0);

    // 12:34:56 frozen in SET_H, shown as MM:SS.
    press(1'b1, 1'b0);
    press_inc(12);
    press(1'b1, 1'b0);
    press_inc(34);
    press(1'b1, 1'b0);
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!(m_mode == 0 && m_secs % 60 == 56) && guard < 2000);
    check("wait_56_timeout", 32'(guard < 2000), 32'(1));
    press(1'b1, 1'b0);
    show_sec = 1'b1;
    read_digits();
    check("mmss_d0", rd[0], 6);
    check("mmss_d1", rd[1], 5);
    check("mmss_d2", rd[2], 4);
    check("mmss_d3", rd[3], 3);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
